// File: rtl/mux_sel_pkg.sv
// Shared definitions for the mux select sequencer and the mux stage it drives.
//   state_e      : sequencer FSM states (3-bit encoding)
//   GuardDefault : default guard-interval length in cycles
//   SEL_A/SEL_B  : select encoding seen by the 2:1 mux
package mux_sel_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StDwellA  = 3'd1,
    StGuardAb = 3'd2,
    StDwellB  = 3'd3,
    StGuardBa = 3'd4
  } state_e;

  localparam int unsigned GuardDefault = 2;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/dwell_counter.sv
// Loadable down-counter with clear, used to time both the dwell and guard intervals.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : force count to zero (highest priority)
//   load_i     : load load_val_i (number of remaining cycles minus one)
//   load_val_i : value to load, PERIOD_W+1 bits so a maximal dwell cannot wrap
//   tc_o       : terminal count, high while the count is zero
module dwell_counter #(
  parameter int unsigned PERIOD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [PERIOD_W:0] load_val_i,
  output logic              tc_o
);

  logic [PERIOD_W:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - {{PERIOD_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/mux_sel_sched.sv
// Sequencer for the 2:1 mux stage: alternates select between A and B with a programmable
// dwell, freezes the operand registers during a guard interval around each changeover and
// pulses beat on the first cycle of every dwell entered from a guard.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en_i         : run enable; low returns to idle on the next edge (no guard)
//   period_i     : dwell length, sampled on entry to each dwell (0 acts as 1)
//   a_i, b_i     : source operands
//   a_o, b_o     : registered operands to the mux A/B inputs
//   sel_o        : mux select (SEL_A / SEL_B)
//   switching_o  : high while in either guard state
//   beat_o       : one-cycle changeover pulse
module mux_sel_sched
  import mux_sel_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned PERIOD_W = 8,
  parameter int unsigned GUARD    = GuardDefault
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [WIDTH-1:0]    a_i,
  input  logic [WIDTH-1:0]    b_i,
  output logic [WIDTH-1:0]    a_o,
  output logic [WIDTH-1:0]    b_o,
  output logic                sel_o,
  output logic                switching_o,
  output logic                beat_o
);

  localparam int unsigned CntW = PERIOD_W + 1;
  localparam logic [CntW-1:0] GuardM1 = CntW'(GUARD - 1);

  state_e state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic sel_q, switching_q, beat_q;

  logic            cnt_clr, cnt_load, cnt_tc;
  logic [CntW-1:0] cnt_val, eff_m1;
  logic            in_guard;

  // Counter is loaded with (cycles - 1); a zero period behaves as a one-cycle dwell.
  assign eff_m1 = (period_i == '0) ? '0
                : ({1'b0, period_i} - {{PERIOD_W{1'b0}}, 1'b1});

  assign in_guard = (state_q == StGuardAb) || (state_q == StGuardBa);

  always_comb begin
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (!en_i) begin
      cnt_clr = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_load = 1'b1;
          cnt_val  = eff_m1;
        end
        StDwellA, StDwellB: begin
          if (cnt_tc) begin
            cnt_load = 1'b1;
            cnt_val  = GuardM1;
          end
        end
        StGuardAb, StGuardBa: begin
          if (cnt_tc) begin
            cnt_load = 1'b1;
            cnt_val  = eff_m1;
          end
        end
        default: cnt_clr = 1'b1;
      endcase
    end
  end

  dwell_counter #(
    .PERIOD_W(PERIOD_W)
  ) u_dwell_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (cnt_clr),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .tc_o      (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sel_q       <= SEL_A;
      switching_q <= 1'b0;
      beat_q      <= 1'b0;
    end else if (!en_i) begin
      state_q     <= StIdle;
      sel_q       <= SEL_A;
      switching_q <= 1'b0;
      beat_q      <= 1'b0;
    end else begin
      beat_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          state_q     <= StDwellA;
          sel_q       <= SEL_A;
          switching_q <= 1'b0;
        end
        StDwellA: begin
          if (cnt_tc) begin
            state_q     <= StGuardAb;
            switching_q <= 1'b1;
          end
        end
        StGuardAb: begin
          if (cnt_tc) begin
            state_q     <= StDwellB;
            sel_q       <= SEL_B;
            switching_q <= 1'b0;
            beat_q      <= 1'b1;
          end
        end
        StDwellB: begin
          if (cnt_tc) begin
            state_q     <= StGuardBa;
            switching_q <= 1'b1;
          end
        end
        StGuardBa: begin
          if (cnt_tc) begin
            state_q     <= StDwellA;
            sel_q       <= SEL_A;
            switching_q <= 1'b0;
            beat_q      <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          sel_q       <= SEL_A;
          switching_q <= 1'b0;
        end
      endcase
    end
  end

  // Operands follow the sources except while a guard is in progress, so the mux output
  // cannot move during a changeover.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (!in_guard) begin
      a_q <= a_i;
      b_q <= b_i;
    end
  end

  assign a_o         = a_q;
  assign b_o         = b_q;
  assign sel_o       = sel_q;
  assign switching_o = switching_q;
  assign beat_o      = beat_q;

endmodule

// File: tb/tb_mux_sel_sched.sv
module tb_mux_sel_sched;

  localparam int Guard = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] period;
  logic [3:0] a_in, b_in;
  logic [3:0] a_out, b_out;
  logic       sel, switching, beat;

  int tests = 0;
  int fails = 0;

  // Schedule model: segments 0=dwell A, 1=guard A->B, 2=dwell B, 3=guard B->A.
  bit       running;
  int       seg;
  int       left;
  logic [3:0] a_e, b_e;
  logic     sel_e, sw_e, beat_e;

  mux_sel_sched #(
    .WIDTH   (4),
    .PERIOD_W(8),
    .GUARD   (Guard)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (en),
    .period_i   (period),
    .a_i        (a_in),
    .b_i        (b_in),
    .a_o        (a_out),
    .b_o        (b_out),
    .sel_o      (sel),
    .switching_o(switching),
    .beat_o     (beat)
  );

  always #5 clk = ~clk;

  function automatic int eff(input logic [7:0] p);
    return (p == 8'd0) ? 1 : int'(p);
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    running = 0; seg = 0; left = 0;
    a_e = '0; b_e = '0; sel_e = 0; sw_e = 0; beat_e = 0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    bit guard_now;
    if (!rst_n) begin
      model_reset();
      return;
    end
    guard_now = running && (seg % 2 == 1);
    if (!guard_now) begin
      a_e = a_in;
      b_e = b_in;
    end
    beat_e = 0;
    if (!en) begin
      running = 0;
      seg = 0;
    end else if (!running) begin
      running = 1;
      seg = 0;
      left = eff(period);
    end else begin
      left--;
      if (left == 0) begin
        seg  = (seg + 1) % 4;
        left = (seg % 2 == 0) ? eff(period) : Guard;
        beat_e = (seg % 2 == 0);
      end
    end
    sel_e = running && (seg >= 2);
    sw_e  = running && (seg % 2 == 1);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".a"}, {4'h0, a_out}, {4'h0, a_e});
    check({tag, ".b"}, {4'h0, b_out}, {4'h0, b_e});
    check({tag, ".sel"}, {7'h0, sel}, {7'h0, sel_e});
    check({tag, ".sw"}, {7'h0, switching}, {7'h0, sw_e});
    check({tag, ".beat"}, {7'h0, beat}, {7'h0, beat_e});
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Step until the model reaches (segment, cycles left), bounded.
  task automatic run_until(input int s, input int l, input string tag);
    int n = 0;
    while (!(running && seg == s && left == l) && n < 600) begin
      step(tag);
      n++;
    end
    check({tag, ".reached"}, {7'h0, (running && seg == s && left == l)}, 8'h01);
  endtask

  task automatic fresh_start(input logic [7:0] p, input string tag);
    en = 1'b0;
    step({tag, ".idle"});
    en = 1'b1;
    period = p;
  endtask

  initial begin
    bit pat_sel3[10];
    bit pat_beat3[10];
    bit pat_sw3[10];
    bit pat_sel0[12];

    pat_sel3  = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    pat_beat3 = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    pat_sw3   = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1};
    pat_sel0  = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};

    model_reset();
    rst_n = 1'b1; en = 1'b1; period = 8'd3; a_in = 4'hF; b_in = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    check("rst.async.a", {4'h0, a_out}, 8'h00);
    for (int i = 0; i < 3; i++) step("rst.hold");
    check("rst.hold.sel", {7'h0, sel}, 8'h00);

    // Release between edges; first edge with en high enters dwell A.
    rst_n = 1'b1;
    step("rst.release");
    check("rst.release.running", {7'h0, running}, 8'h01);

    // Steady run, period 3: directed pattern against constants.
    fresh_start(8'd3, "steady");
    for (int i = 0; i < 10; i++) begin
      step("steady");
      check("steady.pat.sel", {7'h0, sel}, {7'h0, pat_sel3[i]});
      check("steady.pat.beat", {7'h0, beat}, {7'h0, pat_beat3[i]});
      check("steady.pat.sw", {7'h0, switching}, {7'h0, pat_sw3[i]});
    end

    // Guard freeze across guard A->B.
    fresh_start(8'd3, "freeze");
    a_in = 4'h3; b_in = 4'h5;
    run_until(0, 1, "freeze.wait");
    step("freeze.g1");
    check("freeze.g1.sw", {7'h0, switching}, 8'h01);
    a_in = 4'hC; b_in = 4'hA;
    step("freeze.g2");
    check("freeze.g2.a", {4'h0, a_out}, 8'h03);
    check("freeze.g2.b", {4'h0, b_out}, 8'h05);
    step("freeze.dwb");
    check("freeze.dwb.a", {4'h0, a_out}, 8'h03);
    check("freeze.dwb.sel", {7'h0, sel}, 8'h01);
    check("freeze.dwb.beat", {7'h0, beat}, 8'h01);
    step("freeze.dwb2");
    check("freeze.dwb2.a", {4'h0, a_out}, 8'h0C);
    check("freeze.dwb2.b", {4'h0, b_out}, 8'h0A);

    // Period 0 behaves as 1.
    fresh_start(8'd0, "p0");
    for (int i = 0; i < 12; i++) begin
      step("p0");
      check("p0.pat.sel", {7'h0, sel}, {7'h0, pat_sel0[i]});
    end

    // Abort on second cycle of guard B->A, then restart.
    fresh_start(8'd3, "abort");
    run_until(3, 1, "abort.wait");
    en = 1'b0;
    step("abort.drop");
    check("abort.sel", {7'h0, sel}, 8'h00);
    check("abort.beat", {7'h0, beat}, 8'h00);
    check("abort.sw", {7'h0, switching}, 8'h00);
    en = 1'b1; period = 8'd4;
    for (int i = 0; i < 12; i++) step("abort.restart");

    // Period change mid-dwell A only affects the next dwell.
    fresh_start(8'd3, "pchg");
    step("pchg.d1");
    period = 8'd6;
    for (int i = 0; i < 16; i++) step("pchg");

    // Reset in the middle of a guard.
    fresh_start(8'd2, "rstg");
    run_until(1, 2, "rstg.wait");
    rst_n = 1'b0;
    #1;
    check("rstg.sw", {7'h0, switching}, 8'h00);
    check("rstg.sel", {7'h0, sel}, 8'h00);
    check("rstg.a", {4'h0, a_out}, 8'h00);
    model_reset();
    step("rstg.hold");
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step("rstg.after");

    // Maximal dwell must not wrap early.
    fresh_start(8'hFF, "long");
    for (int i = 0; i < 520; i++) step("long");

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      en     = ($urandom_range(0, 19) != 0);
      period = 8'($urandom_range(0, 6));
      a_in   = 4'($urandom);
      b_in   = 4'($urandom);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_sel_sched.md
# mux_sel_sched

Sequencer that drives the select and operand inputs of the 4-bit 2:1 mux stage. It alternates the mux between source A and source B on a programmable dwell period. A guard interval at each changeover freezes the registered operands so the mux output never changes mid-switch. A one-cycle `beat` pulse marks every changeover, giving the rest of the design a heartbeat.

## Interface
- `WIDTH`, 4: operand width; matches the mux data width.
- `PERIOD_W`, 8: width of the `period` input and the dwell counter.
- `GUARD`, 2: guard-interval length in cycles; legal range 1..15.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: run enable. Low forces IDLE.
- `period` input PERIOD_W: dwell length in cycles. Sampled on entry to each dwell state. A value of 0 is treated as 1.
- `a_in` input WIDTH: source A data.
- `b_in` input WIDTH: source B data.
- `a_out` output WIDTH: registered A operand to the mux `A` input.
- `b_out` output WIDTH: registered B operand to the mux `B` input.
- `sel` output 1: mux select; 0 selects A, 1 selects B. Registered.
- `switching` output 1: high during either guard state.
- `beat` output 1: one-cycle pulse on the first cycle of each dwell entered from a guard state.

## Operation
- FSM states: IDLE, DWELL_A, GUARD_AB, DWELL_B, GUARD_BA.
- IDLE
  - `sel`=0. The counter is held at 0.
  - `en`=1 → DWELL_A. Latch `eff_period` = max(`period`,1).
- DWELL_A
  - `sel`=0. The counter counts 0..eff_period-1.
  - When count = eff_period-1 → GUARD_AB, counter cleared.
- GUARD_AB
  - `sel`=0, `switching`=1.
  - After GUARD cycles → DWELL_B: `sel`←1, `beat`←1, re-latch `period`.
- DWELL_B: as DWELL_A with `sel`=1.
  - When count = eff_period-1 → GUARD_BA.
- GUARD_BA
  - `switching`=1, `sel`=1.
  - After GUARD cycles → DWELL_A: `sel`←0, `beat`←1.
- Operand registers
  - Outside the guard states, `a_out`←`a_in` and `b_out`←`b_in` every cycle.
  - In the guard states both hold their values.
- `en` dropping in any non-IDLE state
  - Next edge → IDLE, `sel`←0, counter←0, `beat`←0.
  - There is no guard on abort.
- Counter width: PERIOD_W bits plus 1 extra bit for the guard count. A dwell of 2^PERIOD_W-1 must not wrap early.
- A `period` change mid-dwell has no effect until the next dwell entry.
- `en` held high continuously yields a full cycle of 2·(eff_period+GUARD) cycles.

## Timing
- Reset values, asserted asynchronously:
  - state=IDLE, `sel`=0, `switching`=0, `beat`=0, `a_out`=0, `b_out`=0, counter=0.
  - Reset is released synchronously to `clk` upstream.
- Operand latency: `a_in`/`b_in` → `a_out`/`b_out` is 1 cycle outside the guard states.
- Start: `en` sampled high at edge k → DWELL_A from edge k. The first `beat` appears at edge k+eff_period+GUARD, coincident with `sel` rising.
- `beat` and the `sel` change occur on the same edge. `beat` is never high for 2 consecutive cycles, because eff_period ≥ 1 and GUARD ≥ 1.
- `switching` falls on the same edge that `sel` toggles.
- Reset asserted mid-guard: all outputs go to reset values immediately, with no partial switch.

## Structure
- Shared package `mux_sel_pkg`:
  - FSM state enum (3-bit encoding).
  - GUARD default constant.
  - `sel` encoding constants `SEL_A`=0 and `SEL_B`=1, also used by the mux stage.
- One sub-module, `dwell_counter`:
  - Loadable down- or up-counter with clear.
  - Parameterised by PERIOD_W.
  - Outputs a terminal-count flag.
- The FSM and operand registers stay in the top level.

## Test plan
- Reset: hold `rst_n`=0 while driving `en`=1, `a_in`=4'hF → all outputs 0. Release → DWELL_A on the first edge with `en`=1.
- Steady run: `period`=3, GUARD=2, `en`=1.
  - `sel` toggles every 5 cycles: 0×5, 1×5, ...
  - `beat` pulses exactly at each toggle.
  - `switching` is high for the 2 cycles before each toggle.
- Guard freeze: during GUARD_AB change `a_in` 4'h3→4'hC and `b_in` 4'h5→4'hA.
  - `a_out`/`b_out` hold 4'h3/4'h5 through the guard.
  - They update to C/A one cycle after entering DWELL_B.
- `period`=0 → behaves as 1: sel pattern 0×3, 1×3 with GUARD=2.
- Abort: drop `en` on the second cycle of GUARD_BA → next edge `sel`=0, IDLE, `beat` never pulses. Re-raise `en` → fresh DWELL_A with full dwell.
- Period change: change `period` 3→6 mid-DWELL_A → the current dwell stays 3 cycles; DWELL_B lasts 6.
